minmax_scan_ctrl: RTL and testbench

Sequencer that scans a contiguous window of the 1024-word sample memory and reports the maximum and minimum values with their addresses. It sits between the host control logic and the synchronous-read memory port. It owns address generation, read enables, the compare/update datapath and a start/busy/done handshake, replacing the hand-sequenced load/update strobes of the earlier min/max controller with a single pipelined scan engine.

---
 rtl/minmax_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_minmax_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_scan_ctrl.sv
// minmax_scan_ctrl: pipelined scan of a window of a sync-read sample memory, reporting max/min and their addresses.
// Build option: define MINMAX_SIGNED_EN for two's-complement compares (unsigned when undefined).
module minmax_scan_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [ADDR_W-1:0] max_idx,
    output logic [ADDR_W-1:0] min_idx
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                first_q, first_d;
    logic                err_pend_q, err_pend_d;
    logic                rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [ADDR_W-1:0]   max_idx_q, max_idx_d;
    logic [ADDR_W-1:0]   min_idx_q, min_idx_d;

    logic len_legal;
    logic last_issue;
    logic capture;
    logic gt_max;
    logic lt_min;

    assign len_legal  = (length != '0) && (length <= MAX_LEN);
    assign last_issue = (cnt_q == (len_q - LEN_W'(1)));

    // Abort gates the read strobe in the same cycle it is raised.
    assign mem_rd_en = (state_q == SCAN) && !abort;

    // Abort also wins over a capture landing in the same cycle.
    assign capture = rd_vld_q && !abort && ((state_q == SCAN) || (state_q == DRAIN));

`ifdef MINMAX_SIGNED_EN
    assign gt_max = $signed(mem_rdata) > $signed(max_q);
    assign lt_min = $signed(mem_rdata) < $signed(min_q);
`else
    assign gt_max = mem_rdata > max_q;
    assign lt_min = mem_rdata < min_q;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        err_pend_d = err_pend_q;
        max_d      = max_q;
        min_d      = min_q;
        max_idx_d  = max_idx_q;
        min_idx_d  = min_idx_q;
        rd_vld_d   = mem_rd_en;
        rd_addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_legal) begin
                        state_d    = SCAN;
                        addr_d     = base_addr;
                        len_d      = length;
                        cnt_d      = '0;
                        first_d    = 1'b1;
                        err_pend_d = 1'b0;
                    end else begin
                        // Illegal length spends one busy cycle in DRAIN with nothing in flight.
                        state_d    = DRAIN;
                        err_pend_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = abort ? IDLE : FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            if (first_q) begin
                first_d   = 1'b0;
                max_d     = mem_rdata;
                min_d     = mem_rdata;
                max_idx_d = rd_addr_q;
                min_idx_d = rd_addr_q;
            end else begin
                if (gt_max) begin
                    max_d     = mem_rdata;
                    max_idx_d = rd_addr_q;
                end
                if (lt_min) begin
                    min_d     = mem_rdata;
                    min_idx_d = rd_addr_q;
                end
            end
        end

        busy_d = (state_d == SCAN) || (state_d == DRAIN);
        done_d = (state_d == FIN);
        err_d  = (state_d == FIN) && err_pend_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            err_pend_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            max_q      <= '0;
            min_q      <= '0;
            max_idx_q  <= '0;
            min_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            err_pend_q <= err_pend_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            max_q      <= max_d;
            min_q      <= min_d;
            max_idx_q  <= max_idx_d;
            min_idx_q  <= min_idx_d;
        end
    end

    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign max_val  = max_q;
    assign min_val  = min_q;
    assign max_idx  = max_idx_q;
    assign min_idx  = min_idx_q;

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Bench for minmax_scan_ctrl: table of directed windows, random windows against a reference scan, abort and reset sequences.
`timescale 1ns/1ps
module tb_minmax_scan_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy, done, err;
    logic [DATA_W-1:0] max_val, min_val;
    logic [ADDR_W-1:0] max_idx, min_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mdl_max, mdl_min;
    int                mdl_maxi, mdl_mini;

    minmax_scan_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err),
        .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; garbage on cycles without a read.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= 8'($urandom);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic bit less(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MINMAX_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    // Reference: first word seeds both, strict compares so earliest address wins ties.
    task automatic ref_scan(input int base, input int len);
        logic [DATA_W-1:0] v;
        int a;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % DEPTH;
            v = mem[a];
            if (i == 0) begin
                mdl_max = v; mdl_maxi = a; mdl_min = v; mdl_mini = a;
            end else begin
                if (less(mdl_max, v)) begin mdl_max = v; mdl_maxi = a; end
                if (less(v, mdl_min)) begin mdl_min = v; mdl_mini = a; end
            end
        end
    endtask

    task automatic chk_results(input string tag, input int mx, input int mxi, input int mn, input int mni);
        chk({tag, " max_val"}, 32'(max_val), 32'(mx));
        chk({tag, " max_idx"}, 32'(max_idx), 32'(mxi));
        chk({tag, " min_val"}, 32'(min_val), 32'(mn));
        chk({tag, " min_idx"}, 32'(min_idx), 32'(mni));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk_results(tag, 0, 0, 0, 0);
    endtask

    // Starts a scan and checks strobes cycle by cycle; abort_at/sb_at of 0 mean unused.
    task automatic do_scan(input string tag, input int base, input int len, input int done_cyc,
                           input int abort_at, input int sb_at);
        bit legal;
        bit exp_rd;
        int stop_at;
        int limit;
        legal   = (len >= 1) && (len <= DEPTH);
        stop_at = (abort_at > 0) ? abort_at : 1_000_000;
        limit   = (abort_at > 0) ? abort_at + 2 : done_cyc + 1;
        @(negedge clk);
        base_addr = ADDR_W'(base);
        length    = LEN_W'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            abort = (c == abort_at);
            start = (c == sb_at);
            if (c == sb_at) base_addr = ADDR_W'(base + 77);
            @(negedge clk);
            exp_rd = legal && (c <= len) && (c < stop_at);
            chk($sformatf("%s rd_en c%0d", tag, c), 32'(mem_rd_en), 32'(exp_rd));
            if (exp_rd) chk($sformatf("%s addr c%0d", tag, c), 32'(mem_addr), 32'((base + c - 1) % DEPTH));
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'((c < done_cyc) && (c <= stop_at)));
            chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'((c == done_cyc) && (abort_at == 0)));
            chk($sformatf("%s err c%0d", tag, c), 32'(err), 32'(!legal && (c == done_cyc) && (abort_at == 0)));
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic fill_pat(input int p);
        case (p)
            0: for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
            1: begin
                for (int i = 0; i < DEPTH; i++) mem[i] = 8'd0;
                mem[1020] = 8'd10; mem[1021] = 8'd20; mem[1022] = 8'd30; mem[1023] = 8'd40;
                mem[0] = 8'd5; mem[1] = 8'd50; mem[2] = 8'd1; mem[3] = 8'd7;
            end
            2: for (int i = 0; i < DEPTH; i++) mem[i] = 8'h80;
            3: begin
                for (int i = 0; i < DEPTH; i++) mem[i] = 8'h33;
                mem[0] = 8'h7F; mem[1] = 8'h80;
            end
            4: for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
            5: for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom) | 8'h01;
            default: ;
        endcase
    endtask

    typedef struct {
        int pat; int base; int len; int done_cyc;
        int mx; int mxi; int mn; int mni;
    } vec_t;

    vec_t tbl [6];

    initial begin
`ifdef MINMAX_SIGNED_EN
        tbl[0] = '{0, 0, 1024, 1026, 'h7F, 127, 'h80, 128};
        tbl[3] = '{3, 0, 2, 4, 'h7F, 0, 'h80, 1};
        tbl[4] = '{-1, 0, 0, 2, 'h7F, 0, 'h80, 1};
        tbl[5] = '{-1, 0, 1025, 2, 'h7F, 0, 'h80, 1};
`else
        tbl[0] = '{0, 0, 1024, 1026, 'hFF, 255, 'h00, 0};
        tbl[3] = '{3, 0, 2, 4, 'h80, 1, 'h7F, 0};
        tbl[4] = '{-1, 0, 0, 2, 'h80, 1, 'h7F, 0};
        tbl[5] = '{-1, 0, 1025, 2, 'h80, 1, 'h7F, 0};
`endif
        tbl[1] = '{1, 1020, 8, 10, 50, 1, 1, 2};
        tbl[2] = '{2, 100, 16, 18, 'h80, 100, 'h80, 100};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        fill_pat(4);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        foreach (tbl[k]) begin
            fill_pat(tbl[k].pat);
            do_scan($sformatf("tbl%0d", k), tbl[k].base, tbl[k].len, tbl[k].done_cyc, 0, 0);
            @(negedge clk);
            chk_results($sformatf("tbl%0d", k), tbl[k].mx, tbl[k].mxi, tbl[k].mn, tbl[k].mni);
        end

        mdl_max = 8'(tbl[5].mx); mdl_maxi = tbl[5].mxi;
        mdl_min = 8'(tbl[5].mn); mdl_mini = tbl[5].mni;
        for (int r = 0; r < 24; r++) begin
            int base, len, sb;
            bit legal;
            fill_pat(4);
            base  = int'($urandom_range(0, DEPTH - 1));
            legal = ($urandom_range(0, 5) != 0);
            if (legal) len = int'($urandom_range(1, 80));
            else len = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1025, 2047));
            sb = (legal && len > 3) ? 2 : 0;
            if (legal) ref_scan(base, len);
            do_scan($sformatf("rnd%0d", r), base, len, legal ? len + 2 : 2, 0, sb);
            @(negedge clk);
            chk_results($sformatf("rnd%0d", r), 32'(mdl_max), mdl_maxi, 32'(mdl_min), mdl_mini);
        end

        // Abort at cycle 5: reads 1..3 were captured, the capture in the abort cycle is dropped.
        fill_pat(4);
        ref_scan(900, 3);
        do_scan("abort", 900, 64, 66, 5, 3);
        @(negedge clk);
        chk_results("abort", 32'(mdl_max), mdl_maxi, 32'(mdl_min), mdl_mini);
        repeat (3) begin
            @(negedge clk);
            chk("abort idle rd_en", 32'(mem_rd_en), 32'd0);
            chk("abort idle done", 32'(done), 32'd0);
        end

        // Reset in the middle of a scan on all-nonzero data.
        fill_pat(5);
        @(negedge clk);
        base_addr = ADDR_W'(200); length = LEN_W'(32); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("midrst after c%0d rd_en", c), 32'(mem_rd_en), 32'd0);
            chk($sformatf("midrst after c%0d done", c), 32'(done), 32'd0);
            chk($sformatf("midrst after c%0d max_val", c), 32'(max_val), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
